// File: rtl/uart_tx_frame.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_frame
// Purpose  : UART transmitter. Serialises one character per valid/ready
//            handshake onto a registered TX line (idle high). The frame format
//            (data width, parity, stop bits) is fixed at elaboration. The bit
//            period is a runtime divisor. Back-to-back characters are sent
//            with no idle gap between frames.
// Ports    : i_clk       system clock
//            i_rst       asynchronous active-high reset
//            i_baud_div  clock cycles per bit, latched at accept (0 acts as 1)
//            i_data      character, latched at accept
//            i_valid     character available
//            i_break     (UART_TX_FRAME_BREAK_EN only) hold line low from idle
//            o_ready     character can be accepted this cycle
//            o_busy      frame in progress
//            o_tx        serial output, registered
// Options  : define UART_TX_FRAME_BREAK_EN to add the break input/state
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_frame #(
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int DIV_WIDTH = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [DIV_WIDTH-1:0] i_baud_div,
  input  logic [DATA_BITS-1:0] i_data,
  input  logic                 i_valid,
`ifdef UART_TX_FRAME_BREAK_EN
  input  logic                 i_break,
`endif
  output logic                 o_ready,
  output logic                 o_busy,
  output logic                 o_tx
);

  // --------------------------------------------------------------------------
  // Parameter legality
  // --------------------------------------------------------------------------
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_chk_data_bits
    $error("uart_tx_frame: DATA_BITS must be in 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_chk_parity
    $error("uart_tx_frame: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_chk_stop_bits
    $error("uart_tx_frame: STOP_BITS must be 1 or 2");
  end
  if (DIV_WIDTH < 1) begin : g_chk_div_width
    $error("uart_tx_frame: DIV_WIDTH must be at least 1");
  end

  // --------------------------------------------------------------------------
  // Constants and state encoding
  // --------------------------------------------------------------------------
  localparam int               c_bit_w     = $clog2(DATA_BITS + 2);
  localparam logic [c_bit_w-1:0] c_last_data = c_bit_w'(DATA_BITS - 1);
  localparam logic [c_bit_w-1:0] c_last_stop = c_bit_w'(STOP_BITS - 1);
  localparam logic             c_has_par   = (PARITY != 0);
  localparam logic             c_par_inv   = (PARITY == 2);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_PAR   = 3'd3,
    S_STOP  = 3'd4
`ifdef UART_TX_FRAME_BREAK_EN
    , S_BRK = 3'd5
`endif
  } state_t;

  // --------------------------------------------------------------------------
  // Registers and next-state wires
  // --------------------------------------------------------------------------
  state_t               r_state;
  logic [c_bit_w-1:0]   r_bit;    // data bit index, or stop bit index in STOP
  logic [DIV_WIDTH-1:0] r_cnt;    // cycles elapsed in the current bit
  logic [DIV_WIDTH-1:0] r_div;    // latched divisor, never 0
  logic [DATA_BITS-1:0] r_shift;  // remaining data, LSB is the bit on the line
  logic                 r_par;    // parity bit of the latched character
  logic                 r_tx;

  state_t               w_state_next;
  logic [c_bit_w-1:0]   w_bit_next;
  logic [DIV_WIDTH-1:0] w_cnt_next;
  logic [DIV_WIDTH-1:0] w_div_in;
  logic                 w_shift_en;
  logic                 w_tx_next;
  logic                 w_bit_end;
  logic                 w_accept;

  assign w_bit_end = (r_cnt == r_div - DIV_WIDTH'(1));
  assign w_div_in  = (i_baud_div == '0) ? DIV_WIDTH'(1) : i_baud_div;

  // Ready in idle, and also in the last cycle of the last stop bit so the
  // next start bit follows the stop bit with no idle cycle in between.
  assign o_ready  = (r_state == S_IDLE) ||
                    ((r_state == S_STOP) && (r_bit == c_last_stop) && w_bit_end);
  assign w_accept = i_valid && o_ready;
  assign o_busy   = (r_state != S_IDLE);
  assign o_tx     = r_tx;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_bit_next   = r_bit;
    w_cnt_next   = w_bit_end ? '0 : r_cnt + DIV_WIDTH'(1);
    w_shift_en   = 1'b0;
    w_tx_next    = 1'b1;

    case (r_state)
      S_IDLE: begin
        w_cnt_next = '0;
        if (w_accept) begin
          w_state_next = S_START;
        end
`ifdef UART_TX_FRAME_BREAK_EN
        else if (i_break) begin
          w_state_next = S_BRK;
        end
`endif
      end
      S_START: begin
        if (w_bit_end) begin
          w_state_next = S_DATA;
          w_bit_next   = '0;
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          if (r_bit == c_last_data) begin
            w_state_next = c_has_par ? S_PAR : S_STOP;
            w_bit_next   = '0;
          end else begin
            w_bit_next = r_bit + c_bit_w'(1);
            w_shift_en = 1'b1;
          end
        end
      end
      S_PAR: begin
        if (w_bit_end) begin
          w_state_next = S_STOP;
          w_bit_next   = '0;
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          if (r_bit == c_last_stop) begin
            w_state_next = w_accept ? S_START : S_IDLE;
            w_bit_next   = '0;
          end else begin
            w_bit_next = r_bit + c_bit_w'(1);
          end
        end
      end
`ifdef UART_TX_FRAME_BREAK_EN
      S_BRK: begin
        w_cnt_next = '0;
        // Starting at the last stop index makes the trailing STOP exactly
        // one bit period regardless of STOP_BITS.
        if (!i_break) begin
          w_state_next = S_STOP;
          w_bit_next   = c_last_stop;
        end
      end
`endif
      default: begin
        w_state_next = S_IDLE;
        w_bit_next   = '0;
        w_cnt_next   = '0;
      end
    endcase

    // The line is registered, so drive it from the state being entered.
    case (w_state_next)
      S_START: w_tx_next = 1'b0;
      S_DATA:  w_tx_next = w_shift_en ? r_shift[1] : r_shift[0];
      S_PAR:   w_tx_next = r_par;
`ifdef UART_TX_FRAME_BREAK_EN
      S_BRK:   w_tx_next = 1'b0;
`endif
      default: w_tx_next = 1'b1;
    endcase
  end

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_bit   <= '0;
      r_cnt   <= '0;
      r_div   <= DIV_WIDTH'(1);
      r_shift <= '0;
      r_par   <= 1'b0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_next;
      r_bit   <= w_bit_next;
      r_cnt   <= w_cnt_next;
      r_tx    <= w_tx_next;
      if (w_accept) begin
        r_shift <= i_data;
        r_div   <= w_div_in;
        r_par   <= (^i_data) ^ c_par_inv;
      end else if (w_shift_en) begin
        r_shift <= r_shift >> 1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_frame.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_frame
// Purpose  : Self-checking bench for uart_tx_frame. Four instances cover
//            8N1, 8E1, 8O1 and 8N2. Expected line waveforms are built from the
//            frame rules (start, data LSB first, parity, stop bits, each
//            repeated div cycles) and compared cycle by cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_frame;

  localparam int c_par  [4] = '{0, 1, 2, 0};
  localparam int c_stop [4] = '{1, 1, 1, 2};

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] baud_div;
  logic [7:0]  data  [4];
  logic        valid [4];
  logic        ready [4];
  logic        busy  [4];
  logic        tx    [4];
`ifdef UART_TX_FRAME_BREAK_EN
  logic        brk;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] q_chars [$];
  logic       q_exp   [$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    uart_tx_frame #(
      .DATA_BITS (8),
      .PARITY    ((g == 3) ? 0 : g),
      .STOP_BITS ((g == 3) ? 2 : 1),
      .DIV_WIDTH (16)
    ) u_dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_baud_div (baud_div),
      .i_data     (data[g]),
      .i_valid    (valid[g]),
`ifdef UART_TX_FRAME_BREAK_EN
      .i_break    ((g == 0) ? brk : 1'b0),
`endif
      .o_ready    (ready[g]),
      .o_busy     (busy[g]),
      .o_tx       (tx[g])
    );
  end

  task automatic check(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  // Sends every character in q_chars on instance idx with i_valid kept high,
  // checking o_tx, o_busy and o_ready every cycle against the frame model.
  task automatic run_frames(input int idx);
    int         d;
    int         flen;
    int         nxt;
    logic       acc;
    logic [7:0] c;
    logic [15:0] div_saved;
    logic       frame [$];

    div_saved = baud_div;
    d = (baud_div == 16'd0) ? 1 : int'(baud_div);
    q_exp.delete();
    foreach (q_chars[j]) begin
      c = q_chars[j];
      frame.delete();
      frame.push_back(1'b0);
      for (int b = 0; b < 8; b++) frame.push_back(c[b]);
      if (c_par[idx] == 1) frame.push_back(($countones(c) % 2) == 1);
      if (c_par[idx] == 2) frame.push_back(($countones(c) % 2) == 0);
      for (int s = 0; s < c_stop[idx]; s++) frame.push_back(1'b1);
      foreach (frame[f]) begin
        for (int r = 0; r < d; r++) q_exp.push_back(frame[f]);
      end
    end
    flen = q_exp.size() / q_chars.size();

    @(negedge clk);
    check("idle_ready", ready[idx], 1'b1);
    check("idle_tx", tx[idx], 1'b1);
    valid[idx] = 1'b1;
    data[idx]  = q_chars[0];
    nxt = 1;
    acc = 1'b1;
    for (int k = 0; k < q_exp.size(); k++) begin
      @(negedge clk);
      if (acc) begin
        if (nxt < q_chars.size()) begin
          data[idx] = q_chars[nxt];
          nxt++;
        end else begin
          // Disturb the inputs: the frame in flight must not notice.
          valid[idx] = 1'b0;
          data[idx]  = 8'($urandom);
          baud_div   = 16'($urandom);
        end
      end
      check("tx", tx[idx], q_exp[k]);
      check("busy", busy[idx], 1'b1);
      check("ready", ready[idx], (k % flen) == (flen - 1));
      acc = valid[idx] && ready[idx];
    end
    @(negedge clk);
    check("end_busy", busy[idx], 1'b0);
    check("end_tx", tx[idx], 1'b1);
    check("end_ready", ready[idx], 1'b1);
    baud_div = div_saved;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    int n;

    baud_div = 16'd4;
    for (int i = 0; i < 4; i++) begin
      valid[i] = 1'b0;
      data[i]  = 8'h00;
    end
`ifdef UART_TX_FRAME_BREAK_EN
    brk = 1'b0;
`endif

    // Reset state, observed before any clock edge
    #1 rst = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      check("rst_tx", tx[i], 1'b1);
      check("rst_busy", busy[i], 1'b0);
      check("rst_ready", ready[i], 1'b1);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // 0xA5, 8N1, div 4: 0,1,0,1,0,0,1,0,1,1 -> 40 cycles
    baud_div = 16'd4;
    q_chars.delete(); q_chars.push_back(8'hA5);
    run_frames(0);

    // 0x07 with even and odd parity, 44 cycles each
    q_chars.delete(); q_chars.push_back(8'h07);
    run_frames(1);
    run_frames(2);

    // Back-to-back 0x55, 0xAA: 80 cycles, busy stays high
    q_chars.delete(); q_chars.push_back(8'h55); q_chars.push_back(8'hAA);
    run_frames(0);

    // Divisor 0 behaves as 1: 10-cycle frame
    baud_div = 16'd0;
    q_chars.delete(); q_chars.push_back(8'hFF);
    run_frames(0);

    // Two stop bits, back-to-back
    baud_div = 16'd3;
    q_chars.delete(); q_chars.push_back(8'h3C); q_chars.push_back(8'hC3);
    run_frames(3);

    // Reset during data bit 3 of 0xA5 (that bit is 0 on the line)
    baud_div = 16'd4;
    @(negedge clk);
    valid[0] = 1'b1;
    data[0]  = 8'hA5;
    @(negedge clk);
    valid[0] = 1'b0;
    repeat (16) @(negedge clk);
    check("mid_bit3_tx", tx[0], 1'b0);
    #1 rst = 1'b1;
    #1;
    check("async_rst_tx", tx[0], 1'b1);
    check("async_rst_busy", busy[0], 1'b0);
    #1 rst = 1'b0;
    #1;
    check("post_rst_ready", ready[0], 1'b1);
    check("post_rst_busy", busy[0], 1'b0);
    check("post_rst_tx", tx[0], 1'b1);
    q_chars.delete(); q_chars.push_back(8'hA5);
    run_frames(0);

`ifdef UART_TX_FRAME_BREAK_EN
    // Break for 30 cycles from idle, then one 4-cycle stop bit
    @(negedge clk);
    brk = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      check("brk_tx", tx[0], 1'b0);
      check("brk_ready", ready[0], 1'b0);
      if (k == 30) brk = 1'b0;
    end
    for (int k = 31; k <= 34; k++) begin
      @(negedge clk);
      check("brk_stop_tx", tx[0], 1'b1);
      check("brk_stop_busy", busy[0], 1'b1);
    end
    @(negedge clk);
    check("brk_end_ready", ready[0], 1'b1);
    check("brk_end_busy", busy[0], 1'b0);
`endif

    // Randomised characters, divisors and instances
    for (int r = 0; r < 12; r++) begin
      idx = int'($urandom_range(0, 3));
      n   = int'($urandom_range(1, 3));
      baud_div = 16'($urandom_range(0, 5));
      q_chars.delete();
      for (int j = 0; j < n; j++) q_chars.push_back(8'($urandom));
      run_frames(idx);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
